// File: rtl/psram_line_packer_pkg.sv
// psram_line_packer_pkg
//   Shared constants and state encoding for the PSRAM line packer.
//   A line segment is 32 pixels of 16 bits, packed 4 pixels per 64-bit
//   PSRAM row, 8 rows, with one mask bit per byte.
package psram_line_packer_pkg;

  localparam int PIXELS_PER_ROW = 4;
  localparam int ROWS           = 8;
  localparam int PIX_W          = 16;
  localparam int IDX_W          = 5;
  localparam int ROW_W          = 3;
  localparam int PSRAM_DATA_W   = 64;
  localparam int PSRAM_MASK_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_REQ   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/psram_line_packer_row_mux.sv
// psram_line_packer_row_mux
//   Packs one row of four 16-bit pixels and its 8 per-byte valid bits into
//   a 64-bit PSRAM word and write mask (mask bit 1 = byte not written).
// Ports:
//   i_pix   four pixel columns, column c goes to bits [16c+15:16c]
//   i_valid per-byte valid bits of the row
//   o_data  packed 64-bit row
//   o_mask  byte mask, the inverse of i_valid
module psram_line_packer_row_mux
  import psram_line_packer_pkg::*;
(
  input  logic [PIX_W-1:0]        i_pix [PIXELS_PER_ROW],
  input  logic [PSRAM_MASK_W-1:0] i_valid,
  output logic [PSRAM_DATA_W-1:0] o_data,
  output logic [PSRAM_MASK_W-1:0] o_mask
);

  generate
    for (genvar gi = 0; gi < PIXELS_PER_ROW; gi++) begin : g_col
      assign o_data[gi*PIX_W +: PIX_W] = i_pix[gi];
    end
  endgenerate

  assign o_mask = ~i_valid;

endmodule

// File: rtl/psram_line_packer.sv
// psram_line_packer
//   Pulls pixels start..end of a 32-pixel segment with a read strobe, stores
//   them by pixel index into four column RAMs plus a byte-valid array, then
//   requests the PSRAM write port and bursts all eight rows with byte masks.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start_index/end_index first/last pixel index (inclusive), held stable
//   i_start                 start pulse, accepted only in IDLE
//   o_done                  one-cycle completion pulse
//   o_data_read / i_data    pixel pull strobe; data arrives the next cycle
//   o_psram_write_req/gnt   PSRAM write-port handshake
//   o_psram_data/data_mask  row beat and byte mask (1 = not written)
module psram_line_packer
  import psram_line_packer_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [IDX_W-1:0]        i_start_index,
  input  logic [IDX_W-1:0]        i_end_index,
  input  logic                    i_start,
  output logic                    o_done,
  output logic                    o_data_read,
  input  logic [PIX_W-1:0]        i_data,
  output logic                    o_psram_write_req,
  input  logic                    i_psram_write_gnt,
  output logic [PSRAM_DATA_W-1:0] o_psram_data,
  output logic [PSRAM_MASK_W-1:0] o_psram_data_mask
);

  state_t r_state, w_state_next;

  logic [IDX_W-1:0]        r_rd_idx;   // index of the pixel being pulled
  logic                    r_cap_vld;  // a pixel is on i_data this cycle
  logic [IDX_W-1:0]        r_cap_idx;  // its destination index
  logic [ROW_W-1:0]        r_beat;
  logic [PSRAM_DATA_W-1:0] r_psram_data;
  logic [PSRAM_MASK_W-1:0] r_psram_mask;

  logic [PIX_W-1:0]        r_data_ram_0 [ROWS];
  logic [PIX_W-1:0]        r_data_ram_1 [ROWS];
  logic [PIX_W-1:0]        r_data_ram_2 [ROWS];
  logic [PIX_W-1:0]        r_data_ram_3 [ROWS];
  logic [PSRAM_MASK_W-1:0] r_valid_ram  [ROWS];

  logic                    w_accept;
  logic                    w_load_beat;
  logic [ROW_W-1:0]        w_rd_row;
  logic [PIX_W-1:0]        w_row_pix [PIXELS_PER_ROW];
  logic [PSRAM_DATA_W-1:0] w_row_data;
  logic [PSRAM_MASK_W-1:0] w_row_mask;

  assign w_accept = (r_state == ST_IDLE) && i_start;

  // Beats are registered: row 0 is loaded on the grant edge, each later row
  // on the preceding beat's edge, so beat n appears in cycle G+1+n.
  assign w_load_beat = ((r_state == ST_REQ) && i_psram_write_gnt) ||
                       ((r_state == ST_WRITE) && (r_beat != ROW_W'(ROWS-1)));
  assign w_rd_row    = (r_state == ST_REQ) ? '0 : r_beat + ROW_W'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_next = (i_start_index > i_end_index) ? ST_DONE : ST_READ;
      ST_READ:  if (r_rd_idx == i_end_index) w_state_next = ST_DRAIN;
      ST_DRAIN: w_state_next = ST_REQ;
      ST_REQ:   if (i_psram_write_gnt) w_state_next = ST_WRITE;
      ST_WRITE: if (r_beat == ROW_W'(ROWS-1)) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_data_read       = (r_state == ST_READ);
    o_psram_write_req = (r_state == ST_REQ);
    o_done            = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_idx  <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_beat    <= '0;
    end else begin
      if (w_accept)                  r_rd_idx <= i_start_index;
      else if (r_state == ST_READ)   r_rd_idx <= r_rd_idx + IDX_W'(1);
      r_cap_vld <= (r_state == ST_READ);
      r_cap_idx <= r_rd_idx;
      if (r_state == ST_REQ)         r_beat <= '0;
      else if (r_state == ST_WRITE)  r_beat <= r_beat + ROW_W'(1);
    end
  end

  // Column RAMs: never reset; only written pixels are ever unmasked.
  always_ff @(posedge i_clk) begin
    if (r_cap_vld) begin
      unique case (r_cap_idx[1:0])
        2'd0: r_data_ram_0[r_cap_idx[4:2]] <= i_data;
        2'd1: r_data_ram_1[r_cap_idx[4:2]] <= i_data;
        2'd2: r_data_ram_2[r_cap_idx[4:2]] <= i_data;
        default: r_data_ram_3[r_cap_idx[4:2]] <= i_data;
      endcase
    end
  end

  // Valid array: cleared on every accepted start, two bits set per pixel.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_valid
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          r_valid_ram[gi] <= '0;
        else if (w_accept)
          r_valid_ram[gi] <= '0;
        else if (r_cap_vld && (r_cap_idx[4:2] == ROW_W'(gi)))
          r_valid_ram[gi][{r_cap_idx[1:0], 1'b0} +: 2] <= 2'b11;
      end
    end
  endgenerate

  assign w_row_pix[0] = r_data_ram_0[w_rd_row];
  assign w_row_pix[1] = r_data_ram_1[w_rd_row];
  assign w_row_pix[2] = r_data_ram_2[w_rd_row];
  assign w_row_pix[3] = r_data_ram_3[w_rd_row];

  psram_line_packer_row_mux u_row_mux (
    .i_pix   (w_row_pix),
    .i_valid (r_valid_ram[w_rd_row]),
    .o_data  (w_row_data),
    .o_mask  (w_row_mask)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_psram_data <= '0;
      r_psram_mask <= '1;
    end else if (w_load_beat) begin
      r_psram_data <= w_row_data;
      r_psram_mask <= w_row_mask;
    end else begin
      r_psram_data <= '0;
      r_psram_mask <= '1;
    end
  end

  assign o_psram_data      = r_psram_data;
  assign o_psram_data_mask = r_psram_mask;

endmodule

// File: tb/sim_clkgen.sv
// sim_clkgen
//   Behavioural clock source for simulation: clk starts at 0 and toggles
//   every PERIOD_NS/2.
// Ports:
//   clk  generated clock
module sim_clkgen #(
  parameter int PERIOD_NS = 10
) (
  output logic clk
);
  initial clk = 1'b0;
  always #(PERIOD_NS / 2) clk = ~clk;
endmodule

// File: tb/tb_psram_line_packer.sv
// tb_psram_line_packer
//   Scoreboard bench: each job pushes its eight expected beats into a queue;
//   a monitor pops and compares whenever a beat window follows a grant.
module tb_psram_line_packer;

  logic        clk;
  logic        rst_n;
  logic [4:0]  start_index;
  logic [4:0]  end_index;
  logic        start;
  logic        done;
  logic        data_read;
  logic [15:0] data;
  logic        wreq;
  logic        wgnt;
  logic [63:0] pdata;
  logic [7:0]  pmask;

  sim_clkgen #(.PERIOD_NS(10)) u_clk (.clk(clk));

  psram_line_packer dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start_index     (start_index),
    .i_end_index       (end_index),
    .i_start           (start),
    .o_done            (done),
    .o_data_read       (data_read),
    .i_data            (data),
    .o_psram_write_req (wreq),
    .i_psram_write_gnt (wgnt),
    .o_psram_data      (pdata),
    .o_psram_data_mask (pmask)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  m;
  } beat_t;

  beat_t       exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          gnt_delay = 1;
  logic [15:0] pix_base = 16'h0000;
  int          pix_k = 0;
  int          beats_left = 0;
  bit          done_due = 0;
  int          done_pulses = 0;
  int          rd_cnt = 0;
  int          rd_runs = 0;
  bit          rd_prev = 0;
  int          req_len = 0;
  bit          req_ever = 0;
  logic [63:0] got_data [8];
  logic [7:0]  got_mask [8];

  function automatic logic [15:0] pix(input int k, input logic [15:0] base);
    return {8'(2 * k + 1), 8'(2 * k)} ^ base;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Pixel source: answers each read strobe with the next pixel one cycle later.
  initial begin
    data = 16'h0;
    forever begin
      @(negedge clk);
      if (data_read) begin
        @(posedge clk);
        #1;
        data  = pix(pix_k, pix_base);
        pix_k = pix_k + 1;
      end
    end
  end

  // Arbiter: grant rises after the request has been seen for gnt_delay cycles.
  initial begin
    int req_cycles;
    req_cycles = 0;
    wgnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wreq) begin
        req_cycles++;
        wgnt = (req_cycles > gnt_delay);
      end else begin
        req_cycles = 0;
        wgnt = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t       e;
    logic [63:0] keep;
    int          bi;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beats_left = 0;
        done_due   = 0;
        rd_prev    = 0;
        req_len    = 0;
        continue;
      end
      if (data_read) begin
        rd_cnt++;
        if (!rd_prev) rd_runs++;
      end
      rd_prev = data_read;
      if (done) done_pulses++;
      if (done_due) begin
        chk("done_after_last_beat", 64'(done), 64'd1);
        done_due = 0;
      end
      if (beats_left > 0) begin
        bi = 8 - beats_left;
        got_data[bi] = pdata;
        got_mask[bi] = pmask;
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 64'(bi), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          for (int b = 0; b < 8; b++) keep[8*b +: 8] = e.m[b] ? 8'h00 : 8'hFF;
          chk($sformatf("beat%0d_mask", bi), 64'(pmask), 64'(e.m));
          chk($sformatf("beat%0d_data", bi), pdata & keep, e.d & keep);
        end
        beats_left--;
        if (beats_left == 0) done_due = 1;
      end
      if (wreq) begin
        req_ever = 1;
        req_len++;
      end else begin
        req_len = 0;
      end
      if (wreq && wgnt) begin
        chk("req_held_until_gnt", 64'(req_len), 64'(gnt_delay + 1));
        beats_left = 8;
      end
    end
  end

  task automatic push_expected(input int s, input int e, input logic [15:0] base);
    beat_t b;
    int    i;
    for (int r = 0; r < 8; r++) begin
      b.d = '0;
      b.m = 8'hFF;
      for (int c = 0; c < 4; c++) begin
        i = 4 * r + c;
        if (i >= s && i <= e) begin
          b.d[16*c +: 16] = pix(i - s, base);
          b.m[2*c +: 2]   = 2'b00;
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic issue(input int s, input int e, input int gd, input logic [15:0] base);
    start_index = 5'(s);
    end_index   = 5'(e);
    gnt_delay   = gd;
    pix_base    = base;
    pix_k       = 0;
    done_pulses = 0;
    rd_cnt      = 0;
    rd_runs     = 0;
    req_ever    = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_job(input int s, input int e, input int gd, input logic [15:0] base);
    int cyc;
    push_expected(s, e, base);
    issue(s, e, gd, base);
    @(negedge clk);
    chk("first_read_strobe", 64'(data_read), 64'd1);
    cyc = 0;
    while (done_pulses == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (done_pulses == 0) chk("done_timeout", 64'(cyc), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_pulse_count", 64'(done_pulses), 64'd1);
    chk("read_count", 64'(rd_cnt), 64'(e - s + 1));
    chk("read_runs", 64'(rd_runs), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_index = '0;
    end_index   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_read", 64'(data_read), 64'd0);
    chk("reset_req", 64'(wreq), 64'd0);
    chk("reset_data", pdata, 64'd0);
    chk("reset_mask", 64'(pmask), 64'hFF);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // start=1, end=27, grant one cycle after request
    run_job(1, 27, 1, 16'h0000);
    chk("t1_row0_ram1", 64'(got_data[0][31:16]), 64'h0100);
    chk("t1_row0_ram2", 64'(got_data[0][47:32]), 64'h0302);
    chk("t1_row0_ram3", 64'(got_data[0][63:48]), 64'h0504);
    chk("t1_row6_ram3", 64'(got_data[6][63:48]), 64'h3534);
    chk("t1_mask0", 64'(got_mask[0]), 64'h03);
    chk("t1_mask3", 64'(got_mask[3]), 64'h00);
    chk("t1_mask7", 64'(got_mask[7]), 64'hFF);

    // full segment
    run_job(0, 31, 1, 16'hA55A);
    chk("full_mask7", 64'(got_mask[7]), 64'h00);

    // single pixel at index 5
    run_job(5, 5, 1, 16'h1234);
    chk("single_mask1", 64'(got_mask[1]), 64'hF3);
    chk("single_ram1_row1", 64'(got_data[1][31:16]), 64'h1334);
    chk("single_mask0", 64'(got_mask[0]), 64'hFF);

    // long grant latency
    run_job(2, 13, 20, 16'h00FF);

    // start > end: no reads, no request, done the cycle after start
    issue(9, 3, 1, 16'h0);
    @(negedge clk);
    chk("empty_done_next_cycle", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("empty_done_count", 64'(done_pulses), 64'd1);
    chk("empty_reads", 64'(rd_cnt), 64'd0);
    chk("empty_no_req", 64'(req_ever), 64'd0);

    // reset in the middle of the write burst
    push_expected(0, 31, 16'h0F0F);
    issue(0, 31, 1, 16'h0F0F);
    cyc = 0;
    while (beats_left != 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (beats_left != 5) chk("abort_wait_timeout", 64'(cyc), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_data", pdata, 64'd0);
    chk("abort_mask", 64'(pmask), 64'hFF);
    chk("abort_req", 64'(wreq), 64'd0);
    chk("abort_read", 64'(data_read), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // recovery after the abort
    run_job(10, 21, 3, 16'h5A00);
    chk("recover_mask2", 64'(got_mask[2]), 64'h0F);
    chk("recover_mask5", 64'(got_mask[5]), 64'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
